caliptra_ss_bfm_rst_sequencer: RTL and testbench
================================================

Name: caliptra_ss_bfm_rst_sequencer

Overview:
- Testbench-side controller that services the four reset-request flags raised by the tb_services side of the BFM services interface.
- Arbitrates between pending requests and sequences the hard and warm reset outputs with programmable hold and settle times.
- Returns a one-cycle done pulse per serviced request.
- Sits between the services interface bfm modport and the DUT reset pins.

Parameters:
- ASSERT_CYCLES, 16: cycles a newly asserted reset is held before done; legal range >=1.
- SETTLE_CYCLES, 8: cycles after a reset release before done; legal range >=1.
- CNT_W, 8: counter width; both cycle parameters must be <= 2^CNT_W.

Ports:
- core_clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- assert_hard_rst_flag  input  1  level request; a rising edge is a request.
- deassert_hard_rst_flag  input  1  level request; a rising edge is a request.
- assert_rst_flag  input  1  level request; a rising edge is a request.
- deassert_rst_flag  input  1  level request; a rising edge is a request.
- assert_hard_rst_flag_done  output  1  one-cycle completion pulse.
- deassert_hard_rst_flag_done  output  1  one-cycle completion pulse.
- assert_rst_flag_done  output  1  one-cycle completion pulse.
- deassert_rst_flag_done  output  1  one-cycle completion pulse.
- hard_rst_b  output  1  active-low hard (cold) reset to DUT.
- warm_rst_b  output  1  active-low warm reset to DUT.
- busy  output  1  high while FSM not in IDLE.
- err_illegal  output  1  sticky illegal-sequence flag.

Behaviour:
- Reset values:
  - hard_rst_b=0, warm_rst_b=0: the DUT powers up in reset.
  - All done outputs 0, busy=0, err_illegal=0, FSM=IDLE, pending=0, counter=0.
  - Edge-detect registers reset to 1, so a flag held high through reset does not trigger a request.
- Edge detect: a request is a flag sampled 1 on an edge where it was sampled 0 on the previous edge. Call this edge E0; the pending bit for that request type sets at E0.
- Re-requests:
  - A new request of a type already pending merges with it; one service, one done.
  - A request for the type currently in service sets pending again and is serviced again afterwards.
- Arbitration in IDLE, fixed priority: assert_hard > assert_rst > deassert_hard > deassert_rst. The granted pending bit clears on the grant edge.
- FSM states: IDLE, WAIT, DONE.
  - IDLE to WAIT on the grant edge (E1, one edge after E0 for a lone request).
    - The reset output update takes effect at E1.
    - Counter loads ASSERT_CYCLES-1 for assert requests, SETTLE_CYCLES-1 for deassert requests.
  - WAIT: counter decrements each edge. When counter==0, the next edge moves to DONE.
  - DONE: lasts exactly one cycle with the matching *_done=1, then returns to IDLE. Another grant is possible on the edge after that.
  - Lone-request latency: done is high in the cycle following edge E0+C+1, where C is the applicable cycle parameter.
- Output actions:
  - assert_hard: hard_rst_b=0 and warm_rst_b=0; a hard reset implies a warm reset.
  - assert_rst: warm_rst_b=0; hard_rst_b unchanged.
  - deassert_hard: hard_rst_b=1; warm_rst_b unchanged and stays 0 until deassert_rst.
  - deassert_rst while hard_rst_b=1: warm_rst_b=1.
  - deassert_rst while hard_rst_b=0: illegal. Outputs unchanged, err_illegal sets, full settle wait and done pulse still occur.
  - Redundant requests (assert an already-asserted reset, or deassert an already-released one) are legal. They run the full wait and pulse done with no output change.
- Simultaneous events:
  - Several edges at E0: all set pending and are served in priority order, each with its own wait and done.
  - A flag edge on the DONE cycle is captured normally.
- err_illegal clears only on rst.
- rst asserted mid-operation, asynchronously:
  - Returns every output and state to reset values and drops all pending requests.
  - A done pulse in flight is lost; no done pulse is emitted for the aborted request.

Test Plan:
- Power-up then deassert_hard edge, then deassert_rst edge (defaults) -> hard_rst_b rises at E1, deassert_hard done in cycle after E0+9; warm_rst_b rises on second request, done 9 edges after its E0.
- Edges on assert_hard and deassert_rst at the same E0 with both resets released -> assert_hard served first: both resets 0 at E1, done at E0+17. Then deassert_rst is served with hard_rst_b=0 -> err_illegal=1, done pulses, warm_rst_b stays 0.
- assert_rst edge, a second assert_rst edge during WAIT, and a third before grant -> exactly two done pulses, 18 cycles apart (16 wait plus DONE plus grant).
- ASSERT_CYCLES=1 -> done in cycle after E0+2, busy high for exactly 2 cycles.
- rst pulse 5 cycles into an assert_hard WAIT -> all outputs at reset values immediately, no done pulse, busy=0. A flag held high across reset release produces no request.
- deassert_hard edge with hard_rst_b already 1 -> no output toggle, done after 9 edges, err_illegal stays 0.

Source files
------------

// File: rtl/caliptra_ss_bfm_rst_sequencer.sv
// Reset sequencer for the BFM services interface.
// Watches the four reset-request flags raised by the services side and
// turns each rising edge into a request. It services one request at a time
// in fixed priority order and drives the DUT's active-low hard and warm
// resets. Each serviced request waits for its hold or settle time and then
// produces a one-cycle done pulse.
module caliptra_ss_bfm_rst_sequencer #(
   parameter int ASSERT_CYCLES = 16,  // hold time after an assert, >= 1
   parameter int SETTLE_CYCLES = 8,   // settle time after a release, >= 1
   parameter int CNT_W         = 8    // both cycle counts must fit in 2^CNT_W
) (
   input  logic core_clk,
   input  logic rst,
   input  logic assert_hard_rst_flag,
   input  logic deassert_hard_rst_flag,
   input  logic assert_rst_flag,
   input  logic deassert_rst_flag,
   output logic assert_hard_rst_flag_done,
   output logic deassert_hard_rst_flag_done,
   output logic assert_rst_flag_done,
   output logic deassert_rst_flag_done,
   output logic hard_rst_b,
   output logic warm_rst_b,
   output logic busy,
   output logic err_illegal
);

   // Request slots, listed in arbitration priority order (slot 0 wins).
   localparam int SLOT_AH = 0;  // assert hard reset
   localparam int SLOT_AR = 1;  // assert warm reset
   localparam int SLOT_DH = 2;  // release hard reset
   localparam int SLOT_DR = 3;  // release warm reset

   // The counter is loaded with (cycles - 1) and the WAIT state exits after
   // it reaches zero. A count of 1 therefore gives a single WAIT cycle.
   localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_reg,    state_next;
   logic [CNT_W-1:0] cnt_reg,      cnt_next;
   logic [3:0]       pending_reg,  pending_next;
   logic [3:0]       svc_reg,      svc_next;      // one-hot slot in service
   logic [3:0]       flag_prev_reg;
   logic             hard_reg,     hard_next;     // 1 = hard reset released
   logic             warm_reg,     warm_next;     // 1 = warm reset released
   logic             err_reg,      err_next;

   logic [3:0]       flag_vec;
   logic [3:0]       req;
   logic [3:0]       grant;
   logic [1:0]       grant_idx;
   logic             take_grant;
   logic [3:0]       done_vec;

   assign flag_vec = {deassert_rst_flag, deassert_hard_rst_flag,
                      assert_rst_flag,   assert_hard_rst_flag};

   // A request is a flag seen high now and low on the previous edge.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_edge
         assign req[gi] = flag_vec[gi] & ~flag_prev_reg[gi];
      end
   endgenerate

   // Previous-flag history; resets to all ones so that a flag still held
   // high when reset releases is not mistaken for a fresh request.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         flag_prev_reg <= 4'b1111;
      end else begin
         flag_prev_reg <= flag_vec;
      end
   end

   // Fixed-priority pick among the pending slots.
   always_comb begin
      grant     = 4'b0000;
      grant_idx = 2'd0;
      if (pending_reg[SLOT_AH]) begin
         grant     = 4'b0001;
         grant_idx = 2'(SLOT_AH);
      end else if (pending_reg[SLOT_AR]) begin
         grant     = 4'b0010;
         grant_idx = 2'(SLOT_AR);
      end else if (pending_reg[SLOT_DH]) begin
         grant     = 4'b0100;
         grant_idx = 2'(SLOT_DH);
      end else if (pending_reg[SLOT_DR]) begin
         grant     = 4'b1000;
         grant_idx = 2'(SLOT_DR);
      end
   end

   // Next-state, counter and reset-output logic for the sequencer FSM.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      svc_next   = svc_reg;
      hard_next  = hard_reg;
      warm_next  = warm_reg;
      err_next   = err_reg;
      take_grant = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (|pending_reg) begin
               take_grant = 1'b1;
               state_next = ST_WAIT;
               svc_next   = grant;
               case (grant_idx)
                  2'(SLOT_AH): begin
                     // A cold reset always takes the warm domain down too.
                     hard_next = 1'b0;
                     warm_next = 1'b0;
                     cnt_next  = ASSERT_LOAD;
                  end
                  2'(SLOT_AR): begin
                     warm_next = 1'b0;
                     cnt_next  = ASSERT_LOAD;
                  end
                  2'(SLOT_DH): begin
                     // Warm reset stays asserted until its own release.
                     hard_next = 1'b1;
                     cnt_next  = SETTLE_LOAD;
                  end
                  default: begin
                     // Releasing warm while hard is held is flagged but
                     // still runs the settle time and pulses done.
                     if (hard_reg) begin
                        warm_next = 1'b1;
                     end else begin
                        err_next = 1'b1;
                     end
                     cnt_next = SETTLE_LOAD;
                  end
               endcase
            end
         end
         ST_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = ST_DONE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The granted slot clears; new edges (including one for the slot just
   // granted) are recorded on the same edge.
   always_comb begin
      pending_next = (pending_reg & ~(take_grant ? grant : 4'b0000)) | req;
   end

   // State register; reset puts the DUT into reset and drops all work.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         pending_reg <= 4'b0000;
         svc_reg     <= 4'b0000;
         hard_reg    <= 1'b0;
         warm_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
         svc_reg     <= svc_next;
         hard_reg    <= hard_next;
         warm_reg    <= warm_next;
         err_reg     <= err_next;
      end
   end

   // Done pulses come straight from registered state, so an asynchronous
   // reset removes a pulse that is in flight.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_done
         assign done_vec[gi] = (state_reg == ST_DONE) & svc_reg[gi];
      end
   endgenerate

   assign assert_hard_rst_flag_done   = done_vec[SLOT_AH];
   assign assert_rst_flag_done        = done_vec[SLOT_AR];
   assign deassert_hard_rst_flag_done = done_vec[SLOT_DH];
   assign deassert_rst_flag_done      = done_vec[SLOT_DR];

   assign hard_rst_b  = hard_reg;
   assign warm_rst_b  = warm_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign err_illegal = err_reg;

endmodule

// File: tb/tb_caliptra_ss_bfm_rst_sequencer.sv
// Bench for the reset sequencer. It drives two instances: one with the
// default timing and one with a single-cycle assert hold. A request-level
// model predicts each instance's outputs, and they are compared on every
// cycle. Directed checks with literal expectations pin down key timings.
module tb_caliptra_ss_bfm_rst_sequencer;

   localparam int AC0 = 16;
   localparam int AC1 = 1;
   localparam int SC  = 8;

   logic       core_clk = 1'b0;
   logic       rst      = 1'b1;
   logic [3:0] fl0      = 4'b0000;   // {dr, dh, ar, ah}
   logic [3:0] fl1      = 4'b0000;
   logic [3:0] done0, done1;
   logic       hard0, warm0, busy0, err0;
   logic       hard1, warm1, busy1, err1;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 core_clk = ~core_clk;

   caliptra_ss_bfm_rst_sequencer #(
      .ASSERT_CYCLES(AC0), .SETTLE_CYCLES(SC), .CNT_W(8)
   ) dut0 (
      .core_clk                    (core_clk),
      .rst                         (rst),
      .assert_hard_rst_flag        (fl0[0]),
      .assert_rst_flag             (fl0[1]),
      .deassert_hard_rst_flag      (fl0[2]),
      .deassert_rst_flag           (fl0[3]),
      .assert_hard_rst_flag_done   (done0[0]),
      .assert_rst_flag_done        (done0[1]),
      .deassert_hard_rst_flag_done (done0[2]),
      .deassert_rst_flag_done      (done0[3]),
      .hard_rst_b                  (hard0),
      .warm_rst_b                  (warm0),
      .busy                        (busy0),
      .err_illegal                 (err0)
   );

   caliptra_ss_bfm_rst_sequencer #(
      .ASSERT_CYCLES(AC1), .SETTLE_CYCLES(SC), .CNT_W(8)
   ) dut1 (
      .core_clk                    (core_clk),
      .rst                         (rst),
      .assert_hard_rst_flag        (fl1[0]),
      .assert_rst_flag             (fl1[1]),
      .deassert_hard_rst_flag      (fl1[2]),
      .deassert_rst_flag           (fl1[3]),
      .assert_hard_rst_flag_done   (done1[0]),
      .assert_rst_flag_done        (done1[1]),
      .deassert_hard_rst_flag_done (done1[2]),
      .deassert_rst_flag_done      (done1[3]),
      .hard_rst_b                  (hard1),
      .warm_rst_b                  (warm1),
      .busy                        (busy1),
      .err_illegal                 (err1)
   );

   // ---------------- request-level model ----------------
   // Each service starts at grant edge g, needs c cycles, shows done after
   // edge g+c, and frees the sequencer for a new grant at edge g+c+2.
   int         m_n   [2];
   int         m_g   [2];
   int         m_c   [2];
   int         m_cur [2];
   bit         m_act [2];
   logic [3:0] m_prev[2];
   logic [3:0] m_pend[2];
   logic       m_hard[2];
   logic       m_warm[2];
   logic       m_err [2];
   logic [3:0] exp_done[2];
   logic       exp_busy[2];

   task automatic model_reset(input int i);
      m_n[i] = 0; m_g[i] = 0; m_c[i] = 0; m_cur[i] = 0; m_act[i] = 0;
      m_prev[i] = 4'b1111; m_pend[i] = 4'b0000;
      m_hard[i] = 1'b0; m_warm[i] = 1'b0; m_err[i] = 1'b0;
      exp_done[i] = 4'b0000; exp_busy[i] = 1'b0;
   endtask

   task automatic model_step(input int i, input logic [3:0] fl);
      logic [3:0] rq;
      int t;
      m_n[i]++;
      rq = fl & ~m_prev[i];
      m_prev[i] = fl;
      if (m_act[i] && m_n[i] >= m_g[i] + m_c[i] + 2) m_act[i] = 0;
      if (!m_act[i]) begin
         t = -1;
         for (int b = 0; b < 4; b++) if (t < 0 && m_pend[i][b]) t = b;
         if (t >= 0) begin
            m_pend[i][t] = 1'b0;
            m_act[i] = 1;
            m_g[i]   = m_n[i];
            m_cur[i] = t;
            m_c[i]   = (t < 2) ? ((i == 0) ? AC0 : AC1) : SC;
            case (t)
               0: begin m_hard[i] = 1'b0; m_warm[i] = 1'b0; end
               1: m_warm[i] = 1'b0;
               2: m_hard[i] = 1'b1;
               default: begin
                  if (m_hard[i]) m_warm[i] = 1'b1;
                  else m_err[i] = 1'b1;
               end
            endcase
         end
      end
      m_pend[i] = m_pend[i] | rq;
      exp_busy[i] = m_act[i] && (m_n[i] - m_g[i] <= m_c[i]);
      exp_done[i] = (m_act[i] && (m_n[i] - m_g[i] == m_c[i])) ? 4'(1 << m_cur[i]) : 4'b0000;
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge core_clk or posedge rst);
         if (rst) begin
            model_reset(0);
            model_reset(1);
         end else begin
            model_step(0, fl0);
            model_step(1, fl1);
         end
      end
   end

   initial forever begin
      @(posedge core_clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge core_clk);
      chk("i0_done", 32'(done0), 32'(exp_done[0]));
      chk("i0_busy", 32'(busy0), 32'(exp_busy[0]));
      chk("i0_hard", 32'(hard0), 32'(m_hard[0]));
      chk("i0_warm", 32'(warm0), 32'(m_warm[0]));
      chk("i0_err",  32'(err0),  32'(m_err[0]));
      chk("i1_done", 32'(done1), 32'(exp_done[1]));
      chk("i1_busy", 32'(busy1), 32'(exp_busy[1]));
      chk("i1_hard", 32'(hard1), 32'(m_hard[1]));
      chk("i1_warm", 32'(warm1), 32'(m_warm[1]));
      chk("i1_err",  32'(err1),  32'(m_err[1]));
   end

   // One-cycle flag pulse; returns just after the first negedge following
   // the capturing edge E0 (call that point k=0).
   task automatic pulse(input int inst, input logic [3:0] m);
      @(negedge core_clk);
      #1;
      if (inst == 0) fl0 = fl0 | m; else fl1 = fl1 | m;
      @(negedge core_clk);
      #1;
      if (inst == 0) fl0 = fl0 & ~m; else fl1 = fl1 & ~m;
   endtask

   task automatic wk(input int k);
      repeat (k) @(negedge core_clk);
   endtask

   int q[$];
   int e0;
   int seen;

   initial begin
      // Power-up state while held in reset.
      wk(2);
      chk("rst_hard", 32'(hard0), 0);
      chk("rst_warm", 32'(warm0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_err",  32'(err0),  0);
      #1 rst = 1'b0;
      wk(3);

      // Release hard, then warm.
      pulse(0, 4'b0100);
      chk("dh_k0_busy", 32'(busy0), 0);
      wk(1);
      chk("dh_k1_hard", 32'(hard0), 1);
      chk("dh_k1_warm", 32'(warm0), 0);
      wk(7);
      chk("dh_k8_done", 32'(done0), 0);
      wk(1);
      chk("dh_k9_done", 32'(done0), 32'h4);
      wk(1);
      chk("dh_k10_busy", 32'(busy0), 0);
      pulse(0, 4'b1000);
      wk(1);
      chk("dr_k1_warm", 32'(warm0), 1);
      wk(8);
      chk("dr_k9_done", 32'(done0), 32'h8);
      wk(1);

      // Simultaneous assert_hard + deassert_rst.
      pulse(0, 4'b1001);
      wk(1);
      chk("ahdr_k1_hard", 32'(hard0), 0);
      chk("ahdr_k1_warm", 32'(warm0), 0);
      wk(16);
      chk("ahdr_k17_done", 32'(done0), 32'h1);
      wk(2);
      chk("ahdr_k19_err", 32'(err0), 1);
      wk(8);
      chk("ahdr_k27_done", 32'(done0), 32'h8);
      chk("ahdr_k27_warm", 32'(warm0), 0);
      wk(1);
      chk("ahdr_k28_busy", 32'(busy0), 0);

      // Repeated assert_rst: one during WAIT, one more before the re-grant.
      fork
         begin
            pulse(0, 4'b0010);
            e0 = cyc;
            wk(2);
            pulse(0, 4'b0010);
            wk(3);
            pulse(0, 4'b0010);
         end
         begin
            repeat (70) begin
               @(negedge core_clk);
               if (done0[1]) q.push_back(cyc);
            end
         end
      join
      chk("ar_pulse_count", 32'(q.size()), 2);
      if (q.size() == 2) begin
         chk("ar_first_lat", 32'(q[0] - e0), 17);
         chk("ar_spacing",   32'(q[1] - q[0]), 18);
      end

      // Single-cycle hold on the second instance.
      pulse(1, 4'b0001);
      chk("ac1_k0_busy", 32'(busy1), 0);
      wk(1);
      chk("ac1_k1_busy", 32'(busy1), 1);
      chk("ac1_k1_done", 32'(done1), 0);
      wk(1);
      chk("ac1_k2_done", 32'(done1), 32'h1);
      chk("ac1_k2_busy", 32'(busy1), 1);
      wk(1);
      chk("ac1_k3_busy", 32'(busy1), 0);

      // Reset in the middle of an assert_hard wait.
      pulse(0, 4'b0001);
      wk(5);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_hard", 32'(hard0), 0);
      chk("mid_rst_warm", 32'(warm0), 0);
      chk("mid_rst_busy", 32'(busy0), 0);
      chk("mid_rst_done", 32'(done0), 0);
      chk("mid_rst_err",  32'(err0),  0);
      fl0[1] = 1'b1;
      wk(2);
      #1 rst = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge core_clk);
         if (busy0 || done0 != 4'b0000) seen++;
      end
      chk("held_flag_no_req", 32'(seen), 0);
      #1 fl0[1] = 1'b0;

      // Redundant release of hard reset.
      pulse(0, 4'b0100);
      wk(10);
      pulse(0, 4'b0100);
      wk(1);
      chk("red_k1_hard", 32'(hard0), 1);
      wk(8);
      chk("red_k9_done", 32'(done0), 32'h4);
      chk("red_k9_err",  32'(err0), 0);
      wk(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
